// File: rtl/bg_pixel_fetch.sv
// Background pixel fetch: scrolls raster coordinates into the background image ROM
// and delivers the returned pixel with delay-matched syncs to the VGA pins.
module bg_pixel_fetch #(
    parameter int          IMG_W    = 640,
    parameter int          IMG_H    = 480,
    parameter int          SCR_W    = 640,
    parameter int          ROM_LAT  = 1,
    parameter logic [11:0] BG_COLOR = 12'h000,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  pix_x,
    input  logic [8:0]  pix_y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  scroll_x,
    output logic [18:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [9:0]  scroll_q
);

    localparam int          LAT       = 3 + ROM_LAT;
    localparam logic        SYNC_IDLE = ~SYNC_POL;
    localparam logic [10:0] IMG_W11   = 11'(IMG_W);
    localparam logic [10:0] SCR_W11   = 11'(SCR_W);
    localparam logic [9:0]  IMG_H10   = 10'(IMG_H);

    logic              vsync_q;
    logic              frame_start;
    logic [10:0]       sum;
    logic [10:0]       col_next;
    logic              in_img_next;
    logic [9:0]        col_1;
    logic [8:0]        row_1;
    logic              in_img_1;
    logic              vid_1;
    logic [ROM_LAT:0]  in_img_d;
    logic [ROM_LAT:0]  vid_d;
    logic [LAT-1:0]    hs_sr;
    logic [LAT-1:0]    vs_sr;

    // Frame start is the trailing edge of the vsync pulse.
    assign frame_start = (vsync_q == SYNC_POL) && (vsync_in != SYNC_POL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q  <= SYNC_IDLE;
            scroll_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            vsync_q <= vsync_in;
            if (frame_start)
                scroll_q <= ({1'b0, scroll_x} < IMG_W11) ? scroll_x : 10'(IMG_W - 1);
        end
    end

    // Both operands are below IMG_W, so a single conditional subtract wraps the column.
    always_comb begin
        sum         = {1'b0, pix_x} + {1'b0, scroll_q};
        col_next    = (sum >= IMG_W11) ? (sum - IMG_W11) : sum;
        in_img_next = video_on && ({1'b0, pix_x} < SCR_W11) && ({1'b0, pix_y} < IMG_H10);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_1    <= '0;
            row_1    <= '0;
            in_img_1 <= 1'b0;
            vid_1    <= 1'b0;
            rom_addr <= '0;
            in_img_d <= '0;
            vid_d    <= '0;
            rgb      <= '0;
        end else begin
            col_1    <= col_next[9:0];
            row_1    <= pix_y;
            in_img_1 <= in_img_next;
            vid_1    <= video_on;

            // Address is held outside the image to keep the ROM bus quiet.
            if (in_img_1)
                rom_addr <= 19'(row_1) * 19'(IMG_W) + 19'(col_1);

            in_img_d[0] <= in_img_1;
            vid_d[0]    <= vid_1;
            for (int k = 1; k <= ROM_LAT; k++) begin
                in_img_d[k] <= in_img_d[k-1];
                vid_d[k]    <= vid_d[k-1];
            end

            // Cleared valid bits on reset keep stale ROM words off the pins.
            rgb <= in_img_d[ROM_LAT] ? rom_data : (vid_d[ROM_LAT] ? BG_COLOR : 12'h000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_sr <= {LAT{SYNC_IDLE}};
            vs_sr <= {LAT{SYNC_IDLE}};
        end else begin
            hs_sr <= {hs_sr[LAT-2:0], hsync_in};
            vs_sr <= {vs_sr[LAT-2:0], vsync_in};
        end
    end

    assign hsync_out = hs_sr[LAT-1];
    assign vsync_out = vs_sr[LAT-1];

endmodule
